bsg_fsb_node_iso_ctrl_fsb_domain: RTL and testbench



---
 rtl/bsg_fsb_node_iso_ctrl_fsb_domain.sv | 88 ++++++++
 tb/tb_bsg_fsb_node_iso_ctrl_fsb_domain.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bsg_fsb_node_iso_ctrl_fsb_domain.sv
// bsg_fsb_node_iso_ctrl_fsb_domain: FSB-side level-shifter enable, isolation sequencing and drain FIFO
module bsg_fsb_node_iso_ctrl_fsb_domain #(
  parameter int width_p       = 80,
  parameter int wake_cycles_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               iso_req_i,
  output logic               en_ls_o,
  output logic               iso_ack_o,
  input  logic               node_v_i,
  input  logic [width_p-1:0] node_data_i,
  output logic               node_ready_o,
  output logic               fsb_v_o,
  output logic [width_p-1:0] fsb_data_o,
  input  logic               fsb_ready_i,
  input  logic               fsb_v_i,
  input  logic [width_p-1:0] fsb_data_i,
  output logic               fsb_yumi_o,
  output logic               node_v_o,
  output logic [width_p-1:0] node_data_o,
  input  logic               node_yumi_i
);
  localparam int cw = wake_cycles_p > 1 ? $clog2(wake_cycles_p) : 1;
  typedef enum logic [1:0] {ISOLATED, WAKE, ACTIVE, DRAIN} state_e;
  state_e state, state_n;
  logic [cw-1:0] cnt, cnt_n;
  logic [width_p-1:0] mem [2];
  logic rd_ptr, wr_ptr;
  logic [1:0] count;
  logic en_ls_q, iso_ack_q;
  logic act, empty, full, enq, deq, wake_done;
  assign act          = state == ACTIVE;
  assign empty        = count == 2'd0;
  assign full         = count == 2'd2;
  assign wake_done    = cnt == cw'(wake_cycles_p - 1);
  assign node_ready_o = act & !full;
  assign fsb_v_o      = !empty;
  assign fsb_data_o   = mem[rd_ptr];
  assign enq          = node_v_i & node_ready_o;
  assign deq          = fsb_v_o & fsb_ready_i;
  assign node_v_o     = act & fsb_v_i;
  assign node_data_o  = act ? fsb_data_i : '0;
  assign fsb_yumi_o   = act & node_yumi_i;
  assign en_ls_o      = en_ls_q;
  assign iso_ack_o    = iso_ack_q;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ISOLATED: begin
        state_n = iso_req_i ? ISOLATED : WAKE;
        cnt_n   = '0;
      end
      WAKE: begin
        state_n = iso_req_i ? ISOLATED : (wake_done ? ACTIVE : WAKE);
        cnt_n   = cnt + cw'(1);
      end
      ACTIVE:  state_n = iso_req_i ? DRAIN : ACTIVE;
      DRAIN:   state_n = empty ? ISOLATED : DRAIN;
      default: state_n = ISOLATED;
    endcase
  end
  // enable and ack are flopped from the next state so they never glitch
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= ISOLATED;
      cnt       <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      en_ls_q   <= 1'b0;
      iso_ack_q <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      en_ls_q   <= state_n != ISOLATED;
      iso_ack_q <= state_n == ISOLATED;
      if (enq) wr_ptr <= ~wr_ptr;
      if (deq) rd_ptr <= ~rd_ptr;
      count     <= count + 2'(enq) - 2'(deq);
    end
  end
  always_ff @(posedge clk_i)
    if (enq) mem[wr_ptr] <= node_data_i;
  assert property (@(posedge clk_i) disable iff (reset_i) node_yumi_i |-> node_v_o)
    else $error("node_yumi_i asserted without node_v_o");
endmodule

// File: tb/tb_bsg_fsb_node_iso_ctrl_fsb_domain.sv
// tb_bsg_fsb_node_iso_ctrl_fsb_domain: scoreboard bench for the FSB-domain isolation controller
module tb_bsg_fsb_node_iso_ctrl_fsb_domain;
  logic clk = 0, reset = 1, iso_req = 1;
  logic en_ls, iso_ack, node_v_i = 0, node_ready, fsb_v_o, fsb_ready = 0;
  logic fsb_v_i = 0, fsb_yumi, node_v_o, node_yumi = 0;
  logic [79:0] node_data_i = '0, fsb_data_o, fsb_data_i = '0, node_data_o;
  logic [79:0] fq [$];
  logic [79:0] nq [$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  bsg_fsb_node_iso_ctrl_fsb_domain #(.width_p(80), .wake_cycles_p(4)) dut (
    .clk_i(clk), .reset_i(reset), .iso_req_i(iso_req), .en_ls_o(en_ls), .iso_ack_o(iso_ack),
    .node_v_i(node_v_i), .node_data_i(node_data_i), .node_ready_o(node_ready),
    .fsb_v_o(fsb_v_o), .fsb_data_o(fsb_data_o), .fsb_ready_i(fsb_ready),
    .fsb_v_i(fsb_v_i), .fsb_data_i(fsb_data_i), .fsb_yumi_o(fsb_yumi),
    .node_v_o(node_v_o), .node_data_o(node_data_o), .node_yumi_i(node_yumi));
  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, ".en_ls"}, 80'(en_ls), 80'd0);
    chk({tag, ".iso_ack"}, 80'(iso_ack), 80'd1);
    chk({tag, ".node_ready"}, 80'(node_ready), 80'd0);
    chk({tag, ".fsb_v"}, 80'(fsb_v_o), 80'd0);
    chk({tag, ".fsb_yumi"}, 80'(fsb_yumi), 80'd0);
    chk({tag, ".node_v"}, 80'(node_v_o), 80'd0);
    chk({tag, ".node_data"}, node_data_o, 80'd0);
  endtask
  // monitor: every observed transfer is matched against the scoreboard queues
  always @(negedge clk) begin
    if (fsb_v_o && fsb_ready) begin
      if (fq.size() == 0) begin
        tests++; fails++;
        $display("FAIL fsb_unexpected got=%h exp=none", fsb_data_o);
      end else chk("fsb_data", fsb_data_o, fq.pop_front());
    end
    if (node_v_o) begin
      if (nq.size() == 0) begin
        tests++; fails++;
        $display("FAIL node_unexpected got=%h exp=none", node_data_o);
      end else chk("node_data", node_data_o, nq.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end
  initial begin
    cyc(); cyc();
    chk_reset_vals("reset");
    reset = 0;
    cyc();
    chk("iso_hold.iso_ack", 80'(iso_ack), 80'd1);
    iso_req = 0;
    cyc();
    chk("wake.iso_ack", 80'(iso_ack), 80'd0);
    chk("wake.en_ls", 80'(en_ls), 80'd1);
    for (int i = 0; i < 4; i++) begin
      chk("wake.node_ready", 80'(node_ready), 80'd0);
      cyc();
    end
    chk("active.node_ready", 80'(node_ready), 80'd1);
    fq.push_back(80'hA); fq.push_back(80'hB); fq.push_back(80'hC);
    node_v_i = 1; node_data_i = 80'hA;
    cyc();
    node_data_i = 80'hB;
    #1 chk("fifo1.node_ready", 80'(node_ready), 80'd1);
    chk("fifo1.fsb_v", 80'(fsb_v_o), 80'd1);
    cyc();
    node_data_i = 80'hC;
    #1 chk("full.node_ready", 80'(node_ready), 80'd0);
    chk("full.head", fsb_data_o, 80'hA);
    cyc();
    chk("full_hold.node_ready", 80'(node_ready), 80'd0);
    fsb_ready = 1;
    cyc();
    chk("space.node_ready", 80'(node_ready), 80'd1);
    cyc();
    node_v_i = 0;
    chk("last.head", fsb_data_o, 80'hC);
    cyc();
    chk("emptied.fsb_v", 80'(fsb_v_o), 80'd0);
    fsb_ready = 0;
    nq.push_back(80'h55);
    fsb_v_i = 1; fsb_data_i = 80'h55; node_yumi = 1;
    #1 chk("pass.node_v", 80'(node_v_o), 80'd1);
    chk("pass.node_data", node_data_o, 80'h55);
    chk("pass.fsb_yumi", 80'(fsb_yumi), 80'd1);
    cyc();
    fsb_v_i = 0; node_yumi = 0;
    fq.push_back(80'h11); fq.push_back(80'h22);
    node_v_i = 1; node_data_i = 80'h11;
    cyc();
    node_data_i = 80'h22;
    cyc();
    node_v_i = 0; iso_req = 1; fsb_ready = 1;
    cyc();
    chk("drain.en_ls", 80'(en_ls), 80'd1);
    chk("drain.iso_ack", 80'(iso_ack), 80'd0);
    chk("drain.node_ready", 80'(node_ready), 80'd0);
    chk("drain.head", fsb_data_o, 80'h22);
    fsb_v_i = 1; fsb_data_i = 80'h66;
    #1 chk("drain.node_v", 80'(node_v_o), 80'd0);
    chk("drain.node_data", node_data_o, 80'd0);
    chk("drain.fsb_yumi", 80'(fsb_yumi), 80'd0);
    cyc();
    chk("drain_empty.fsb_v", 80'(fsb_v_o), 80'd0);
    chk("drain_empty.iso_ack", 80'(iso_ack), 80'd0);
    cyc();
    chk("drained.en_ls", 80'(en_ls), 80'd0);
    chk("drained.iso_ack", 80'(iso_ack), 80'd1);
    fsb_v_i = 0; fsb_ready = 0; iso_req = 0;
    cyc();
    fsb_v_i = 1; fsb_data_i = 80'h33;
    #1 chk("wake2.en_ls", 80'(en_ls), 80'd1);
    chk("wake2.node_v", 80'(node_v_o), 80'd0);
    chk("wake2.node_data", node_data_o, 80'd0);
    chk("wake2.fsb_yumi", 80'(fsb_yumi), 80'd0);
    cyc(); cyc();
    iso_req = 1;
    cyc();
    chk("abort.en_ls", 80'(en_ls), 80'd0);
    chk("abort.iso_ack", 80'(iso_ack), 80'd1);
    chk("abort.node_v", 80'(node_v_o), 80'd0);
    fsb_v_i = 0; iso_req = 0;
    repeat (5) cyc();
    chk("active2.node_ready", 80'(node_ready), 80'd1);
    node_v_i = 1; node_data_i = 80'h44;
    cyc();
    node_v_i = 0; iso_req = 1;
    cyc();
    chk("drain2.fsb_v", 80'(fsb_v_o), 80'd1);
    chk("drain2.en_ls", 80'(en_ls), 80'd1);
    reset = 1;
    cyc();
    chk_reset_vals("mid_drain_reset");
    reset = 0;
    cyc();
    chk("after_reset.fsb_v", 80'(fsb_v_o), 80'd0);
    chk("fq_drained", 80'(fq.size()), 80'd0);
    chk("nq_drained", 80'(nq.size()), 80'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
